fsm_input_conditioner: RTL and testbench

//  Upstream stage of the microcoded FSM: turns 2 raw async control lines into the

---
 rtl/fsm_input_conditioner_if.sv | 31 +++
 rtl/fsm_input_conditioner.sv | 164 ++++++++++++++++
 tb/tb_fsm_input_conditioner.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_input_conditioner_if.sv
// Handshake bundle between raw control lines, the input conditioner
// and the downstream FSM that consumes the conditioned code.
interface fsm_input_conditioner_if;
  logic [1:0] raw_in;
  logic       advance;
  logic [1:0] in;
  logic       in_valid;
  logic       fifo_full;
  logic       overflow;
  logic       deb_busy;

  modport master (
    output raw_in,
    output advance,
    input  in,
    input  in_valid,
    input  fifo_full,
    input  overflow,
    input  deb_busy
  );

  modport slave (
    input  raw_in,
    input  advance,
    output in,
    output in_valid,
    output fifo_full,
    output overflow,
    output deb_busy
  );
endinterface

// File: rtl/fsm_input_conditioner.sv
// Sync + debounce + code FIFO feeding the microcoded FSM `in` port.
// FSM_IN_COALESCE_EN: when defined, a push into a full FIFO overwrites the tail.
module fsm_input_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         CNT_W           = 3,
  parameter int         FIFO_DEPTH      = 4,
  parameter logic [1:0] RESET_CODE      = 2'b00
) (
  input logic                    clk,
  input logic                    rst_n,
  fsm_input_conditioner_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    COUNT
  } deb_state_t;

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       cand;
  logic [CNT_W-1:0] cnt;
  deb_state_t       state;

  logic [1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic [1:0]       in_q;
  logic             ovf_q;

  logic             push;
  logic [1:0]       push_code;
  logic             pop;
  logic             full;
  logic             wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RESET_CODE;
      sync2 <= RESET_CODE;
    end else begin
      sync1 <= bus.raw_in;
      sync2 <= sync1;
    end
  end

  // Accept fires on the sample that completes the stable run.
  always_comb begin
    push      = 1'b0;
    push_code = cand;
    unique case (state)
      IDLE: begin
        if (sync2 != deb && DEBOUNCE_CYCLES == 1) begin
          push      = 1'b1;
          push_code = sync2;
        end
      end
      COUNT: begin
        if (sync2 == cand && cnt == CNT_LAST) begin
          push = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      deb   <= RESET_CODE;
      cand  <= RESET_CODE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sync2 != deb) begin
            if (push) begin
              deb <= sync2;
            end else begin
              cand  <= sync2;
              cnt   <= CNT_ONE;
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          if (sync2 != cand) begin
            if (sync2 == deb) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cand <= sync2;
              cnt  <= CNT_ONE;
            end
          end else if (push) begin
            deb   <= cand;
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full  = (occ == OCC_FULL);
  assign pop   = bus.advance && (occ != '0);
  assign wr_en = push && (!full || pop);

  // Storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_code;
    end
`ifdef FSM_IN_COALESCE_EN
    else if (push) begin
      mem[AW'(wr_ptr - 1'b1)] <= push_code;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      in_q   <= RESET_CODE;
      ovf_q  <= 1'b0;
    end else begin
      if (pop) begin
        in_q   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !wr_en) begin
        ovf_q <= 1'b1;
      end
      unique case (1'b1)
        wr_en && !pop: occ <= occ + 1'b1;
        pop && !wr_en: occ <= occ - 1'b1;
        default:       occ <= occ;
      endcase
    end
  end

  assign bus.in        = in_q;
  assign bus.in_valid  = (occ != '0);
  assign bus.fifo_full = full;
  assign bus.overflow  = ovf_q;
  assign bus.deb_busy  = (state == COUNT);

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Scoreboard bench for fsm_input_conditioner: expected codes queued at
// drive time, popped and compared when advance presents them on `in`.
module tb_fsm_input_conditioner;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsm_input_conditioner_if bus ();

  fsm_input_conditioner dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] q[$];
  logic [1:0] exp_code;
  logic [1:0] last_deb;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw change to accepted push takes 2 sync + 4 debounce edges.
  task automatic send(input logic [1:0] c);
    bus.raw_in = c;
    if (q.size() < DEPTH) begin
      q.push_back(c);
    end else begin
`ifdef FSM_IN_COALESCE_EN
      q[q.size()-1] = c;
`endif
    end
    last_deb = c;
    tick(6);
  endtask

  task automatic pulse_adv();
    bus.advance = 1'b1;
    tick(1);
    bus.advance = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    bus.raw_in = 2'b00;
    bus.advance = 1'b0;
    q.delete();
    last_deb = 2'b00;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    bus.raw_in = 2'b00;
    bus.advance = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    n_cmp++;
    if (bus.in !== 2'b00 || bus.in_valid !== 1'b0 ||
        bus.fifo_full !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.deb_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: in=%b v=%b f=%b o=%b b=%b need 00 0 0 0 0",
               bus.in, bus.in_valid, bus.fifo_full,
               bus.overflow, bus.deb_busy);
    end
    send(2'b01);
    bus.raw_in = 2'b11;
    tick(4);
    n_cmp++;
    if (bus.deb_busy !== 1'b1 || bus.in_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_busy: b=%b v=%b need 1 1",
               bus.deb_busy, bus.in_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.in !== 2'b00 || bus.in_valid !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.deb_busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: in=%b v=%b o=%b b=%b need 00 0 0 0",
               bus.in, bus.in_valid, bus.overflow, bus.deb_busy);
    end
    q.delete();
    last_deb = 2'b00;
    bus.raw_in = 2'b00;
    tick(2);
    rst_n = 1'b1;
    tick(8);
    n_cmp++;
    if (bus.in_valid !== 1'b0 || bus.deb_busy !== 1'b0) begin
      n_err++;
      $display("FAIL no_partial_push: v=%b b=%b need 0 0",
               bus.in_valid, bus.deb_busy);
    end
  endtask

  task automatic test_single();
    bus.raw_in = 2'b10;
    q.push_back(2'b10);
    last_deb = 2'b10;
    tick(5);
    n_cmp++;
    if (bus.in_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: in_valid=%b need 0", bus.in_valid);
    end
    tick(1);
    n_cmp++;
    if (bus.in_valid !== 1'b1) begin
      n_err++;
      $display("FAIL latency_6: in_valid=%b need 1", bus.in_valid);
    end
    pulse_adv();
    exp_code = q.pop_front();
    n_cmp++;
    if (bus.in !== exp_code || bus.in_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pop: in=%b v=%b need %b 0",
               bus.in, bus.in_valid, exp_code);
    end
  endtask

  task automatic test_glitch();
    send(2'b00);
    pulse_adv();
    exp_code = q.pop_front();
    n_cmp++;
    if (bus.in !== exp_code) begin
      n_err++;
      $display("FAIL glitch_setup: in=%b need %b", bus.in, exp_code);
    end
    bus.raw_in = 2'b01;
    tick(2);
    bus.raw_in = 2'b00;
    tick(1);
    n_cmp++;
    if (bus.deb_busy !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_busy: deb_busy=%b need 1", bus.deb_busy);
    end
    tick(3);
    n_cmp++;
    if (bus.deb_busy !== 1'b0 || bus.in_valid !== 1'b0 ||
        bus.in !== 2'b00) begin
      n_err++;
      $display("FAIL glitch_reject: b=%b v=%b in=%b need 0 0 00",
               bus.deb_busy, bus.in_valid, bus.in);
    end
  endtask

  task automatic test_fill();
    send(2'b01);
    send(2'b10);
    send(2'b11);
    n_cmp++;
    if (bus.fifo_full !== 1'b0) begin
      n_err++;
      $display("FAIL fill_3: fifo_full=%b need 0", bus.fifo_full);
    end
    send(2'b00);
    n_cmp++;
    if (bus.fifo_full !== 1'b1 || bus.in_valid !== 1'b1) begin
      n_err++;
      $display("FAIL fill_4: f=%b v=%b need 1 1",
               bus.fifo_full, bus.in_valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pulse_adv();
      exp_code = q.pop_front();
      n_cmp++;
      if (bus.in !== exp_code) begin
        n_err++;
        $display("FAIL fill_pop%0d: in=%b need %b", i, bus.in, exp_code);
      end
    end
    n_cmp++;
    if (bus.in_valid !== 1'b0 || bus.fifo_full !== 1'b0) begin
      n_err++;
      $display("FAIL fill_drained: v=%b f=%b need 0 0",
               bus.in_valid, bus.fifo_full);
    end
  endtask

  task automatic test_overflow();
    send(2'b01);
    send(2'b10);
    send(2'b11);
    send(2'b00);
    send(2'b01);
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.fifo_full !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_flag: o=%b f=%b need 1 1",
               bus.overflow, bus.fifo_full);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pulse_adv();
      exp_code = q.pop_front();
      n_cmp++;
      if (bus.in !== exp_code) begin
        n_err++;
        $display("FAIL ovf_pop%0d: in=%b need %b", i, bus.in, exp_code);
      end
    end
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.in_valid !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_sticky: o=%b v=%b need 1 0",
               bus.overflow, bus.in_valid);
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    send(2'b01);
    send(2'b10);
    send(2'b11);
    send(2'b00);
    bus.raw_in = 2'b10;
    last_deb = 2'b10;
    tick(5);
    bus.advance = 1'b1;
    tick(1);
    bus.advance = 1'b0;
    exp_code = q.pop_front();
    q.push_back(2'b10);
    n_cmp++;
    if (bus.in !== exp_code || bus.fifo_full !== 1'b1 ||
        bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL push_pop_full: in=%b f=%b o=%b need %b 1 0",
               bus.in, bus.fifo_full, bus.overflow, exp_code);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pulse_adv();
      exp_code = q.pop_front();
      n_cmp++;
      if (bus.in !== exp_code) begin
        n_err++;
        $display("FAIL ppf_pop%0d: in=%b need %b", i, bus.in, exp_code);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] c;
    logic [1:0] held;
    held = bus.in;
    pulse_adv();
    n_cmp++;
    if (bus.in !== held || bus.in_valid !== 1'b0) begin
      n_err++;
      $display("FAIL empty_advance: in=%b v=%b need %b 0",
               bus.in, bus.in_valid, held);
    end
    for (int i = 0; i < 6; i++) begin
      c = 2'($urandom_range(0, 3));
      if (c == last_deb) c = c ^ 2'b01;
      send(c);
      pulse_adv();
      exp_code = q.pop_front();
      n_cmp++;
      if (bus.in !== exp_code || bus.in_valid !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_%0d: in=%b v=%b need %b 0",
                 i, bus.in, bus.in_valid, exp_code);
      end
    end
  endtask

  initial begin
    bus.raw_in = 2'b00;
    bus.advance = 1'b0;
    last_deb = 2'b00;
    exp_code = 2'b00;
    test_reset();
    test_single();
    test_glitch();
    test_fill();
    test_overflow();
    test_push_pop_full();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, need finish before");
    $fatal(1, "timeout");
  end

endmodule
